// File: rtl/cordic_vec_iter.sv
// -----------------------------------------------------------------------------
// cordic_vec_iter
//
// Iterative vectoring-mode CORDIC. Converts a complex sample (real, imaginary)
// into magnitude and phase with one microrotation per clock over 7 iterations.
// It is the inverse of the rotation-mode twiddle rotator. It sits after the FFT
// output stage and feeds bin magnitude and phase to post-processing.
//
// Build option:
//   CORDIC_VEC_GAIN_COMP_EN - when defined, SCALE multiplies x by 1/K with a
//                             shift-add network so that oMag ~= |v|. When
//                             undefined, oMag = x and carries the CORDIC gain
//                             of ~1.6467. Latency, handshake and oPhase are
//                             the same in both builds.
//
// Ports:
//   iClk       in   1     clock, rising edge
//   iRst       in   1     asynchronous reset, active-high
//   iValid     in   1     input sample valid
//   iReal      in   n     signed real part
//   iImage     in   n     signed imaginary part
//   oReady     out  1     block idle, able to accept a sample
//   oValid     out  1     one-cycle result strobe
//   oMag       out  n+2   unsigned magnitude
//   oPhase     out  9     signed phase, 1 LSB = pi/200 rad, range -200..+200
//   oDbgState  out  2     current FSM state (0 IDLE, 1 ITER, 2 SCALE)
//
// Handshake: a sample transfers on a rising edge where iValid and oReady are
// both high. oReady is high exactly while the FSM is idle, which includes the
// cycle in which oValid is high. iValid while oReady is low is ignored and
// nothing is queued. oValid is a strobe with no backpressure. oMag and oPhase
// hold their value until the next result is loaded.
// -----------------------------------------------------------------------------
module cordic_vec_iter #(
  parameter int n = 33
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iValid,
  input  logic [n-1:0] iReal,
  input  logic [n-1:0] iImage,
  output logic         oReady,
  output logic         oValid,
  output logic [n+1:0] oMag,
  output logic [8:0]   oPhase,
  output logic [1:0]   oDbgState
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    SCALE = 2'd2
  } stateType;

  stateType            state;
  logic signed [n+1:0] x;
  logic signed [n+1:0] y;
  logic signed [9:0]   z;
  logic [2:0]          iterIdx;
  logic                zeroIn;

  logic signed [n+1:0] xExt;
  logic signed [n+1:0] yExt;
  logic signed [n+1:0] xShift;
  logic signed [n+1:0] yShift;
  logic signed [n+1:0] magScaled;
  logic signed [9:0]   alpha;
  logic [8:0]          phaseSat;

  assign oDbgState = state;

  // Two extra bits of headroom: negating -2^(n-1) and the CORDIC growth of
  // about 2.33 * 2^(n-1) both fit without overflow.
  always_comb begin
    xExt = $signed({{2{iReal[n-1]}}, iReal});
    yExt = $signed({{2{iImage[n-1]}}, iImage});
  end

  // Both shifted terms come from the pre-update x and y.
  always_comb begin
    xShift = x >>> iterIdx;
    yShift = y >>> iterIdx;
  end

  // atan(2^-i) expressed in units of pi/200 rad, rounded to integers.
  always_comb begin
    alpha = 10'sd0;
    unique case (iterIdx)
      3'd0:    alpha = 10'sd50;
      3'd1:    alpha = 10'sd30;
      3'd2:    alpha = 10'sd16;
      3'd3:    alpha = 10'sd8;
      3'd4:    alpha = 10'sd4;
      3'd5:    alpha = 10'sd2;
      3'd6:    alpha = 10'sd1;
      default: alpha = 10'sd0;
    endcase
  end

`ifdef CORDIC_VEC_GAIN_COMP_EN
  // 1/K ~= 0.60722 as 1/2 + 1/8 - 1/64 - 1/512 - 1/4096 + 1/16384 - 1/65536.
  always_comb begin
    magScaled = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9)
              - (x >>> 12) + (x >>> 14) - (x >>> 16);
  end
`else
  always_comb begin
    magScaled = x;
  end
`endif

  // z can reach +-311 after the quadrant preset plus the microrotations, so it
  // is clamped to the half-turn range before it is narrowed to 9 bits.
  always_comb begin
    if (z > 10'sd200) begin
      phaseSat = 9'd200;
    end else if (z < -10'sd200) begin
      phaseSat = 9'h138;  // -200 in 9-bit two's complement
    end else begin
      phaseSat = z[8:0];
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      iterIdx <= '0;
      zeroIn  <= 1'b0;
      oReady  <= 1'b1;
      oValid  <= 1'b0;
      oMag    <= '0;
      oPhase  <= '0;
    end else begin
      oValid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (iValid) begin
            zeroIn  <= (iReal == '0) && (iImage == '0);
            iterIdx <= 3'd0;
            oReady  <= 1'b0;
            state   <= ITER;
            // The left half-plane is folded into the right half-plane by a
            // rotation of pi. The preset sign follows the original imaginary
            // part, so the negative real axis reports +200.
            if (xExt[n+1]) begin
              x <= -xExt;
              y <= -yExt;
              z <= iImage[n-1] ? -10'sd200 : 10'sd200;
            end else begin
              x <= xExt;
              y <= yExt;
              z <= 10'sd0;
            end
          end
        end

        ITER: begin
          // Rotate toward the positive real axis. y >= 0 means rotate
          // clockwise.
          if (!y[n+1]) begin
            x <= x + yShift;
            y <= y - xShift;
            z <= z + alpha;
          end else begin
            x <= x - yShift;
            y <= y + xShift;
            z <= z - alpha;
          end
          if (iterIdx == 3'd6) begin
            state <= SCALE;
          end else begin
            iterIdx <= iterIdx + 3'd1;
          end
        end

        SCALE: begin
          // A zero vector has no defined angle. Report 0/0 instead of the
          // residue left by the iterations.
          oMag   <= zeroIn ? '0 : $unsigned(magScaled);
          oPhase <= zeroIn ? '0 : phaseSat;
          oValid <= 1'b1;
          oReady <= 1'b1;
          state  <= IDLE;
        end

        default: begin
          state  <= IDLE;
          oReady <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vec_iter.sv
// -----------------------------------------------------------------------------
// tb_cordic_vec_iter
//
// Self-checking bench for cordic_vec_iter. The reference is ideal floating
// point polar conversion (sqrt / atan2) scaled by the build's expected gain.
// Each result is accepted within a tolerance that covers the 7-step angle
// resolution and fixed-point truncation.
// -----------------------------------------------------------------------------
module tb_cordic_vec_iter;

  localparam int  N  = 33;
  localparam real PI = 3.14159265358979;
`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam real GAIN = 1.0;
`else
  localparam real GAIN = 1.64669;
`endif

  logic         clk;
  logic         iRst;
  logic         iValid;
  logic [N-1:0] iReal;
  logic [N-1:0] iImage;
  logic         oReady;
  logic         oValid;
  logic [N+1:0] oMag;
  logic [8:0]   oPhase;
  logic [1:0]   oDbgState;

  int n_checks = 0;
  int n_fails  = 0;

  cordic_vec_iter #(.n(N)) dut (
    .iClk      (clk),
    .iRst      (iRst),
    .iValid    (iValid),
    .iReal     (iReal),
    .iImage    (iImage),
    .oReady    (oReady),
    .oValid    (oValid),
    .oMag      (oMag),
    .oPhase    (oPhase),
    .oDbgState (oDbgState)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic real abs_r(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic void model(input logic signed [N-1:0] re,
                                input logic signed [N-1:0] im,
                                output real mag, output real ph);
    real r;
    real i;
    r = real'(re);
    i = real'(im);
    mag = $sqrt(r * r + i * i) * GAIN;
    if (re == 0 && im == 0) ph = 0.0;
    else ph = $atan2(i, r) * 200.0 / PI;
  endfunction

  // ---------------- driver ----------------
  // Presents one sample and returns in the cycle where oValid rises.
  // lat counts the cycles after the accept edge (a lat of 30 means timeout).
  task automatic send_and_wait(input logic signed [N-1:0] re,
                               input logic signed [N-1:0] im,
                               output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!oReady && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    iValid = 1'b1;
    iReal  = re;
    iImage = im;
    @(posedge clk);
    @(negedge clk);
    iValid = 1'b0;
    lat = 1;
    while (!oValid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int lat;
    #1;
    n_checks++;
    if (oValid !== 1'b0) begin n_fails++; $display("FAIL reset_oValid: got %b want 0", oValid); end
    n_checks++;
    if (oReady !== 1'b1) begin n_fails++; $display("FAIL reset_oReady: got %b want 1", oReady); end
    n_checks++;
    if (oMag !== '0) begin n_fails++; $display("FAIL reset_oMag: got %0d want 0", oMag); end
    n_checks++;
    if (oPhase !== '0) begin n_fails++; $display("FAIL reset_oPhase: got %0d want 0", oPhase); end
    @(negedge clk);
    iRst = 1'b0;
    // Load nonzero outputs, then assert reset between edges.
    send_and_wait(33'sd1000, 33'sd1000, lat);
    @(negedge clk);
    #2 iRst = 1'b1;
    #1;
    n_checks++;
    if (oMag !== '0 || oPhase !== '0 || oValid !== 1'b0 || oReady !== 1'b1) begin
      n_fails++;
      $display("FAIL async_reset: got mag=%0d ph=%0d v=%b r=%b want 0 0 0 1", oMag, oPhase, oValid, oReady);
    end
    @(negedge clk);
    iRst = 1'b0;
  endtask

  task automatic test_directed();
    longint t_re[8] = '{1000, 1000, 0, -1000, 0, -1000, -64'sd4294967296, 0};
    longint t_im[8] = '{0, 1000, 1000, 0, -1000, -1000, -64'sd4294967296, 0};
    int     t_ph[8] = '{0, 50, 100, 200, -100, -150, -150, 0};
    int     t_pt[8] = '{2, 2, 2, 2, 2, 2, 2, 0};
    real    t_ma[8] = '{3.0, 5.0, 5.0, 5.0, 5.0, 5.0, 0.0, 0.0};
    real    t_mr[8] = '{0.0, 0.0, 0.005, 0.005, 0.005, 0.005, 0.005, 0.0};
    logic signed [N-1:0] re;
    logic signed [N-1:0] im;
    real exp_mag;
    real exp_ph;
    real tol;
    int  lat;
    for (int k = 0; k < 8; k++) begin
      re = N'(t_re[k]);
      im = N'(t_im[k]);
      model(re, im, exp_mag, exp_ph);
      send_and_wait(re, im, lat);
      n_checks++;
      if (lat !== 9) begin n_fails++; $display("FAIL directed[%0d] latency: got %0d want 9", k, lat); end
      tol = t_ma[k] * GAIN + t_mr[k] * exp_mag;
      n_checks++;
      if (abs_r(real'(oMag) - exp_mag) > tol) begin
        n_fails++;
        $display("FAIL directed[%0d] mag: got %0d want %0.1f +-%0.1f", k, oMag, exp_mag, tol);
      end
      n_checks++;
      if (abs_r(real'($signed(oPhase)) - real'(t_ph[k])) > real'(t_pt[k])) begin
        n_fails++;
        $display("FAIL directed[%0d] phase: got %0d want %0d +-%0d", k, $signed(oPhase), t_ph[k], t_pt[k]);
      end
      n_checks++;
      if (oReady !== 1'b1) begin n_fails++; $display("FAIL directed[%0d] ready_with_valid: got %b want 1", k, oReady); end
      @(negedge clk);
      n_checks++;
      if (oValid !== 1'b0) begin n_fails++; $display("FAIL directed[%0d] strobe_width: got %b want 0", k, oValid); end
    end
  endtask

  task automatic test_random();
    logic signed [N-1:0] re;
    logic signed [N-1:0] im;
    logic [31:0] a;
    logic [31:0] b;
    real exp_mag;
    real exp_ph;
    real tol;
    int  lat;
    for (int k = 0; k < 25; k++) begin
      a = $urandom;
      b = $urandom;
      re = {a[31], a};
      im = {b[31], b};
      if (k % 3 == 1) begin
        re = re >>> $urandom_range(20, 0);
        im = im >>> $urandom_range(20, 0);
      end
      if (abs_r(real'(re)) + abs_r(real'(im)) < 4096.0) re = 33'sd5000;
      model(re, im, exp_mag, exp_ph);
      send_and_wait(re, im, lat);
      n_checks++;
      if (lat !== 9) begin n_fails++; $display("FAIL random[%0d] latency: got %0d want 9", k, lat); end
      tol = 16.0 * GAIN + 0.005 * exp_mag;
      n_checks++;
      if (abs_r(real'(oMag) - exp_mag) > tol) begin
        n_fails++;
        $display("FAIL random[%0d] mag (%0d,%0d): got %0d want %0.1f", k, re, im, oMag, exp_mag);
      end
      n_checks++;
      if (abs_r(real'($signed(oPhase)) - exp_ph) > 2.5) begin
        n_fails++;
        $display("FAIL random[%0d] phase (%0d,%0d): got %0d want %0.2f", k, re, im, $signed(oPhase), exp_ph);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2*N-1:0] exp_q[$];
    logic [2*N-1:0] item;
    logic signed [N-1:0] s_re[3];
    logic signed [N-1:0] s_im[3];
    logic signed [N-1:0] re;
    logic signed [N-1:0] im;
    logic [31:0] junk;
    real exp_mag;
    real exp_ph;
    logic exp_ready;
    logic exp_valid;
    s_re[0] = 33'sd2000;   s_im[0] = -33'sd500;
    s_re[1] = -33'sd30000; s_im[1] = 33'sd12000;
    s_re[2] = 33'sd700;    s_im[2] = 33'sd2500;
    repeat (2) @(negedge clk);
    for (int c = 0; c <= 27; c++) begin
      exp_ready = (c % 9 == 0);
      exp_valid = (c % 9 == 0) && (c > 0);
      n_checks++;
      if (oReady !== exp_ready) begin n_fails++; $display("FAIL b2b c=%0d oReady: got %b want %b", c, oReady, exp_ready); end
      n_checks++;
      if (oValid !== exp_valid) begin n_fails++; $display("FAIL b2b c=%0d oValid: got %b want %b", c, oValid, exp_valid); end
      if (exp_valid && exp_q.size() > 0) begin
        item = exp_q.pop_front();
        re = item[2*N-1:N];
        im = item[N-1:0];
        model(re, im, exp_mag, exp_ph);
        n_checks++;
        if (abs_r(real'(oMag) - exp_mag) > 8.0 * GAIN + 0.005 * exp_mag) begin
          n_fails++;
          $display("FAIL b2b c=%0d mag: got %0d want %0.1f", c, oMag, exp_mag);
        end
        n_checks++;
        if (abs_r(real'($signed(oPhase)) - exp_ph) > 2.5) begin
          n_fails++;
          $display("FAIL b2b c=%0d phase: got %0d want %0.2f", c, $signed(oPhase), exp_ph);
        end
      end
      if (c < 27) begin
        iValid = 1'b1;
        if (c % 9 == 0) begin
          iReal  = s_re[c / 9];
          iImage = s_im[c / 9];
          exp_q.push_back({s_re[c / 9], s_im[c / 9]});
        end else begin
          junk   = $urandom;
          iReal  = {junk[31], junk};
          junk   = $urandom;
          iImage = {junk[31], junk};
        end
      end else begin
        iValid = 1'b0;
      end
      @(negedge clk);
    end
    iValid = 1'b0;
    n_checks++;
    if (exp_q.size() !== 0) begin n_fails++; $display("FAIL b2b leftover: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int  pulses;
    int  lat;
    real exp_mag;
    real exp_ph;
    repeat (2) @(negedge clk);
    iValid = 1'b1;
    iReal  = 33'sd1000;
    iImage = 33'sd1000;
    @(posedge clk);
    @(negedge clk);
    iValid = 1'b0;
    repeat (3) @(posedge clk);
    #2 iRst = 1'b1;
    #1;
    n_checks++;
    if (oReady !== 1'b1 || oValid !== 1'b0 || oMag !== '0 || oPhase !== '0) begin
      n_fails++;
      $display("FAIL midreset outputs: got r=%b v=%b mag=%0d ph=%0d want 1 0 0 0", oReady, oValid, oMag, oPhase);
    end
    @(negedge clk);
    iRst = 1'b0;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (oValid) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin n_fails++; $display("FAIL midreset stale_valid: got %0d pulses want 0", pulses); end
    model(33'sd3000, 33'sd4000, exp_mag, exp_ph);
    send_and_wait(33'sd3000, 33'sd4000, lat);
    n_checks++;
    if (lat !== 9) begin n_fails++; $display("FAIL midreset latency: got %0d want 9", lat); end
    n_checks++;
    if (abs_r(real'(oMag) - exp_mag) > 10.0 * GAIN) begin
      n_fails++;
      $display("FAIL midreset mag: got %0d want %0.1f", oMag, exp_mag);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    iRst   = 1'b1;
    iValid = 1'b0;
    iReal  = '0;
    iImage = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
    $finish;
  end

endmodule
